// File: rtl/phase_addr_gen.sv
// phase_addr_gen: phase-accumulator address generator for the dual-port sine ROM.
// addr1 is the integer part of the phase accumulator. addr2 is addr1 + offset.
// Frequency words arrive over a valid/ready handshake. With LOAD_ON_WRAP=1 a new word
// is held in a shadow register and takes effect at the next phase wrap, so the frequency
// changes without a phase jump.
// Optional feature macro: PHASE_DITHER_EN adds LFSR dither to the fractional phase
// before addr1 is truncated from it.
//
// Handshake: incr_in transfers on any rising edge where incr_valid && incr_ready.
// incr_ready is high only in IDLE. incr_in is sampled only on a transfer edge.
// A transfer is accepted whether or not en is high.
module phase_addr_gen #(
  parameter int                   ACC_WIDTH    = 16,
  parameter int                   ADDR_WIDTH   = 8,
  parameter logic [ACC_WIDTH-1:0] RESET_INCR   = 16'h0100,
  parameter bit                   LOAD_ON_WRAP = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  sync,
  input  logic [ACC_WIDTH-1:0]  incr_in,
  input  logic                  incr_valid,
  output logic                  incr_ready,
  input  logic [ADDR_WIDTH-1:0] offset,
  output logic [ADDR_WIDTH-1:0] addr1,
  output logic [ADDR_WIDTH-1:0] addr2,
  output logic                  wrap,
  output logic                  pending,
  output logic                  dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_PENDING = 1'b1} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [ACC_WIDTH-1:0]  r_incr;
  logic [ACC_WIDTH-1:0]  r_shadow;
  logic                  r_wrap;
  logic [ACC_WIDTH-1:0]  w_sum;
  logic                  w_carry;
  logic                  w_xfer;
  logic                  w_load_shadow;

  assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, r_incr};
  assign w_xfer           = incr_valid && (r_state == S_IDLE);
  assign incr_ready       = (r_state == S_IDLE);
  assign pending          = (r_state == S_PENDING);
  assign dbg_state        = r_state;
  assign wrap             = r_wrap;

  // Shadow word is committed on a carrying step, or early on sync.
  assign w_load_shadow = (r_state == S_PENDING) && (sync || (en && w_carry));

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // FSM next state. A transfer in IDLE wins even alongside sync, because sync is
  // treated as having happened first.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_xfer && LOAD_ON_WRAP) w_next_state = S_PENDING;
      S_PENDING: if (w_load_shadow)          w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Phase accumulator and wrap pulse. sync has priority over en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc  <= '0;
      r_wrap <= 1'b0;
    end else if (sync) begin
      r_acc  <= '0;
      r_wrap <= 1'b0;
    end else if (en) begin
      r_acc  <= w_sum;
      r_wrap <= w_carry;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  // Frequency word and shadow register. Loading the shadow happens only in PENDING
  // and a transfer happens only in IDLE, so the two paths never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_incr   <= RESET_INCR;
      r_shadow <= '0;
    end else begin
      if (w_load_shadow)                  r_incr   <= r_shadow;
      else if (w_xfer && !LOAD_ON_WRAP)   r_incr   <= incr_in;
      if (w_xfer && LOAD_ON_WRAP)         r_shadow <= incr_in;
    end
  end

`ifdef PHASE_DITHER_EN
  localparam int FRAC = ACC_WIDTH - ADDR_WIDTH;

  logic [7:0]           r_lfsr;
  logic [ACC_WIDTH-1:0] w_dither;

  // Dither LFSR x^8+x^6+x^5+x^4+1. It advances on en steps and holds on sync.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              r_lfsr <= 8'h01;
    else if (en && !sync)  r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  // Dither word: the LFSR truncated or zero-extended to the fractional phase bits.
  always_comb begin
    w_dither = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < FRAC) w_dither[i] = r_lfsr[i];
    end
  end

  // addr1 comes from the dithered phase. wrap still follows the raw accumulator.
  always_comb begin
    addr1 = ADDR_WIDTH'((r_acc + w_dither) >> FRAC);
  end
`else
  // addr1 is a pure truncation of the accumulator.
  always_comb begin
    addr1 = r_acc[ACC_WIDTH-1 -: ADDR_WIDTH];
  end
`endif

  assign addr2 = addr1 + offset;

endmodule

// File: tb/tb_phase_addr_gen.sv
// tb_phase_addr_gen: directed bench for phase_addr_gen.
// Instance dut uses LOAD_ON_WRAP=1 and instance dut_b uses LOAD_ON_WRAP=0.
module tb_phase_addr_gen;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // LOAD_ON_WRAP=1 instance signals
  logic        en, sync, incr_valid, incr_ready, wrap, pending, dbg_state;
  logic [15:0] incr_in;
  logic [7:0]  offset, addr1, addr2;

  // LOAD_ON_WRAP=0 instance signals
  logic        en_b, sync_b, incr_valid_b, incr_ready_b, wrap_b, pending_b, dbg_state_b;
  logic [15:0] incr_in_b;
  logic [7:0]  offset_b, addr1_b, addr2_b;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  phase_addr_gen #(.LOAD_ON_WRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .incr_in(incr_in),
    .incr_valid(incr_valid), .incr_ready(incr_ready), .offset(offset),
    .addr1(addr1), .addr2(addr2), .wrap(wrap), .pending(pending),
    .dbg_state(dbg_state)
  );

  phase_addr_gen #(.LOAD_ON_WRAP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .sync(sync_b), .incr_in(incr_in_b),
    .incr_valid(incr_valid_b), .incr_ready(incr_ready_b), .offset(offset_b),
    .addr1(addr1_b), .addr2(addr2_b), .wrap(wrap_b), .pending(pending_b),
    .dbg_state(dbg_state_b)
  );

  // scoreboard compare
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance n rising edges, then sample 1 ns later
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] k8;
    rst = 1'b0; en = 1'b1; sync = 1'b0; incr_valid = 1'b0; incr_in = '0; offset = 8'd64;
    en_b = 1'b0; sync_b = 1'b0; incr_valid_b = 1'b0; incr_in_b = '0; offset_b = '0;
    #12;
    // reset state
    check_eq("rst_addr1", addr1, 0);
    check_eq("rst_addr2", addr2, 64);
    check_eq("rst_ready", incr_ready, 1);
    check_eq("rst_pending", pending, 0);
    check_eq("rst_wrap", wrap, 0);
    check_eq("rst_addr1_b", addr1_b, 0);
    rst = 1'b1;

    // test 1: free run at RESET_INCR, one LSB of addr1 per step
    for (int k = 1; k <= 256; k++) begin
      k8 = k[7:0];
      exp_q.push_back(k8);
    end
    for (int k = 1; k <= 256; k++) begin
      step(1);
      check_eq("t1_addr1", addr1, exp_q.pop_front());
      if (k == 1)   check_eq("t1_addr2_e1", addr2, 65);
      if (k == 255) begin
        check_eq("t1_addr2_e255", addr2, 63);
        check_eq("t1_wrap_e255", wrap, 0);
      end
      if (k == 256) check_eq("t1_wrap_e256", wrap, 1);
    end
    step(1);
    check_eq("t1_wrap_e257", wrap, 0);
    check_eq("t1_addr1_e257", addr1, 1);
    step(63);
    check_eq("t2_addr1_start", addr1, 8'h40);

    // test 2: deferred frequency word, applied at wrap
    incr_valid = 1'b1; incr_in = 16'h0080;
    step(1);
    incr_valid = 1'b0;
    check_eq("t2_addr1_xfer", addr1, 8'h41);
    check_eq("t2_ready_low", incr_ready, 0);
    check_eq("t2_pending_high", pending, 1);
    step(190);
    check_eq("t2_addr1_ff", addr1, 8'hFF);
    check_eq("t2_pending_still", pending, 1);
    step(1);
    check_eq("t2_addr1_wrap", addr1, 0);
    check_eq("t2_wrap_pulse", wrap, 1);
    check_eq("t2_pending_clr", pending, 0);
    check_eq("t2_ready_back", incr_ready, 1);
    step(1);
    check_eq("t2_half_a", addr1, 0);
    check_eq("t2_wrap_gone", wrap, 0);
    step(1);
    check_eq("t2_half_b", addr1, 1);
    step(2);
    check_eq("t2_half_c", addr1, 2);

    // test 4: sync clears, then offset wrap on addr2 and en=0 hold
    offset = 8'hF0;
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    check_eq("t4_sync_addr1", addr1, 0);
    check_eq("t4_sync_wrap", wrap, 0);
    step(64);
    check_eq("t4_addr1", addr1, 8'h20);
    check_eq("t4_addr2", addr2, 8'h10);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check_eq("t4_hold_addr1", addr1, 8'h20);
      check_eq("t4_hold_wrap", wrap, 0);
    end

    // test 6: pending word applied by sync
    incr_valid = 1'b1; incr_in = 16'h0300;
    step(1);
    incr_valid = 1'b0;
    check_eq("t6_pending", pending, 1);
    check_eq("t6_ready", incr_ready, 0);
    check_eq("t6_addr1_held", addr1, 8'h20);
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    check_eq("t6_addr1", addr1, 0);
    check_eq("t6_pending_clr", pending, 0);
    check_eq("t6_wrap", wrap, 0);
    check_eq("t6_ready", incr_ready, 1);
    en = 1'b1;
    step(1);
    en = 1'b0;
    check_eq("t6_step_addr1", addr1, 3);
    check_eq("t6_step_addr2", addr2, 8'hF3);

    // test 5: async reset while pending discards shadow
    incr_valid = 1'b1; incr_in = 16'h0040;
    step(1);
    incr_valid = 1'b0;
    check_eq("t5_pending", pending, 1);
    rst = 1'b0;
    #1;
    check_eq("t5_addr1", addr1, 0);
    check_eq("t5_addr2", addr2, 8'hF0);
    check_eq("t5_pending", pending, 0);
    check_eq("t5_ready", incr_ready, 1);
    rst = 1'b1;
    en = 1'b1;
    step(1);
    check_eq("t5_step1", addr1, 1);
    step(1);
    check_eq("t5_step2", addr1, 2);
    en = 1'b0;

    // test 3: LOAD_ON_WRAP=0 loads on the transfer edge
    en_b = 1'b1;
    step(16);
    check_eq("t3_addr1_start", addr1_b, 8'h10);
    incr_valid_b = 1'b1; incr_in_b = 16'h0200;
    step(1);
    incr_valid_b = 1'b0;
    check_eq("t3_addr1_xfer", addr1_b, 8'h11);
    check_eq("t3_pending", pending_b, 0);
    check_eq("t3_ready", incr_ready_b, 1);
    step(1);
    check_eq("t3_addr1_next", addr1_b, 8'h13);
    check_eq("t3_pending2", pending_b, 0);
    step(1);
    check_eq("t3_addr1_next2", addr1_b, 8'h15);
    en_b = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
